// File: rtl/stage4_load_forward_buffer.sv
// -----------------------------------------------------------------------------
// stage4_load_forward_buffer
//
// Store-data forwarding from in-flight loads. The live stage-4 writeback and a
// DEPTH-entry history of retired writebacks are searched for the youngest
// writer of the stage-3 store's rs2. If that writer is a load, its data is
// offered to the store-data mux together with the index of the source.
// A younger non-load writer shadows any older load; the ALU forward path owns
// that case, so this block stays silent.
//
// Ports:
//   CLK                in   rising-edge clock
//   RESET              in   asynchronous active-low reset
//   STALL              in   hold history and counter
//   FLUSH              in   clear history valid bits (dominates STALL)
//   S4_REG_WRITE       in   stage-4 instruction writes a register
//   S4_MEM_READ        in   stage-4 instruction is a load
//   S4_REG_ADDR        in   stage-4 destination register
//   S4_LOAD_DATA       in   stage-4 load result
//   S3_MEM_WRITE       in   stage-3 instruction is a store
//   S3_REG_READ_ADDR2  in   stage-3 rs2 (store data source)
//   FWD_EN             out  select forwarded data for the store
//   FWD_DATA           out  forwarded load data (0 when not forwarding)
//   FWD_IDX            out  0 = live stage 4, k = history entry k-1
//   FWD_COUNT          out  saturating count of forward events
// -----------------------------------------------------------------------------
module stage4_load_forward_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic                  FLUSH,
  input  logic                  S4_REG_WRITE,
  input  logic                  S4_MEM_READ,
  input  logic [ADDR_WIDTH-1:0] S4_REG_ADDR,
  input  logic [DATA_WIDTH-1:0] S4_LOAD_DATA,
  input  logic                  S3_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] S3_REG_READ_ADDR2,
  output logic                  FWD_EN,
  output logic [DATA_WIDTH-1:0] FWD_DATA,
  output logic [IDX_W-1:0]      FWD_IDX,
  output logic [CNT_WIDTH-1:0]  FWD_COUNT
);

  // History, entry 0 is the youngest.
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_is_load;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_s4_valid;
  logic                  w_found;
  logic                  w_fwd_en;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [IDX_W-1:0]      w_fwd_idx;

  // Writes to x0 are architecturally discarded, so they never become writers.
  assign w_s4_valid = S4_REG_WRITE && (S4_REG_ADDR != '0);

  // Youngest-first priority scan; the first valid address match decides,
  // whether or not it is a load.
  always_comb begin
    w_found    = 1'b0;
    w_fwd_en   = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    if (S3_MEM_WRITE && (S3_REG_READ_ADDR2 != '0)) begin
      if (w_s4_valid && (S4_REG_ADDR == S3_REG_READ_ADDR2)) begin
        w_found = 1'b1;
        if (S4_MEM_READ) begin
          w_fwd_en   = 1'b1;
          w_fwd_data = S4_LOAD_DATA;
          w_fwd_idx  = '0;
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found && r_valid[k] && (r_addr[k] == S3_REG_READ_ADDR2)) begin
          w_found = 1'b1;
          if (r_is_load[k]) begin
            w_fwd_en   = 1'b1;
            w_fwd_data = r_data[k];
            w_fwd_idx  = IDX_W'(k + 1);
          end
        end
      end
    end
  end

  // History shift register. A flush only needs to invalidate entries; the
  // stale payload is harmless once valid is low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid   <= '0;
      r_is_load <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
      end
    end else if (FLUSH) begin
      r_valid <= '0;
    end else if (!STALL) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_valid[k]   <= r_valid[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_addr[k]    <= r_addr[k-1];
        r_data[k]    <= r_data[k-1];
      end
      r_valid[0]   <= w_s4_valid;
      r_is_load[0] <= S4_MEM_READ;
      r_addr[0]    <= S4_REG_ADDR;
      r_data[0]    <= S4_LOAD_DATA;
    end
  end

  // Forward-event counter: survives flush, freezes on stall, saturates.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count <= '0;
    end else if (w_fwd_en && !STALL && (r_count != '1)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign FWD_EN    = w_fwd_en;
  assign FWD_DATA  = w_fwd_data;
  assign FWD_IDX   = w_fwd_idx;
  assign FWD_COUNT = r_count;

endmodule

// File: tb/tb_stage4_load_forward_buffer.sv
// -----------------------------------------------------------------------------
// Directed bench for stage4_load_forward_buffer (DEPTH=2). A second instance
// built with a 4-bit counter shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_stage4_load_forward_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        FLUSH;
  logic        S4_REG_WRITE;
  logic        S4_MEM_READ;
  logic [4:0]  S4_REG_ADDR;
  logic [31:0] S4_LOAD_DATA;
  logic        S3_MEM_WRITE;
  logic [4:0]  S3_REG_READ_ADDR2;

  logic        FWD_EN;
  logic [31:0] FWD_DATA;
  logic [1:0]  FWD_IDX;
  logic [15:0] FWD_COUNT;

  logic        FWD_EN_4;
  logic [31:0] FWD_DATA_4;
  logic [1:0]  FWD_IDX_4;
  logic [3:0]  FWD_COUNT_4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  stage4_load_forward_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .S4_REG_WRITE(S4_REG_WRITE), .S4_MEM_READ(S4_MEM_READ),
    .S4_REG_ADDR(S4_REG_ADDR), .S4_LOAD_DATA(S4_LOAD_DATA),
    .S3_MEM_WRITE(S3_MEM_WRITE), .S3_REG_READ_ADDR2(S3_REG_READ_ADDR2),
    .FWD_EN(FWD_EN), .FWD_DATA(FWD_DATA), .FWD_IDX(FWD_IDX),
    .FWD_COUNT(FWD_COUNT)
  );

  stage4_load_forward_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2), .CNT_WIDTH(4)
  ) dut_c4 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .S4_REG_WRITE(S4_REG_WRITE), .S4_MEM_READ(S4_MEM_READ),
    .S4_REG_ADDR(S4_REG_ADDR), .S4_LOAD_DATA(S4_LOAD_DATA),
    .S3_MEM_WRITE(S3_MEM_WRITE), .S3_REG_READ_ADDR2(S3_REG_READ_ADDR2),
    .FWD_EN(FWD_EN_4), .FWD_DATA(FWD_DATA_4), .FWD_IDX(FWD_IDX_4),
    .FWD_COUNT(FWD_COUNT_4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic s4(input logic we, input logic mr, input logic [4:0] a, input logic [31:0] d);
    S4_REG_WRITE = we; S4_MEM_READ = mr; S4_REG_ADDR = a; S4_LOAD_DATA = d;
  endtask

  task automatic s3(input logic mw, input logic [4:0] rs2);
    S3_MEM_WRITE = mw; S3_REG_READ_ADDR2 = rs2;
  endtask

  task automatic fwd(input string tag, input logic en, input logic [31:0] d, input logic [1:0] idx);
    #1;
    check({tag, ".en"},   {31'd0, FWD_EN}, {31'd0, en});
    check({tag, ".data"}, FWD_DATA, d);
    check({tag, ".idx"},  {30'd0, FWD_IDX}, {30'd0, idx});
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    s4(0, 0, 0, 0); s3(0, 0);
    #12;
    fwd("rst", 0, 0, 0);
    check("rst.count", {16'd0, FWD_COUNT}, 32'd0);
    RESET = 1'b1;
    tick();

    // 1: live stage-4 load forwarded with zero latency
    s4(1, 1, 5, 32'hDEADBEEF); s3(1, 5);
    fwd("t1.live", 1, 32'hDEADBEEF, 0);
    tick();
    s4(0, 0, 0, 0); s3(0, 0);
    #1 check("t1.count", {16'd0, FWD_COUNT}, 32'd1);

    // 2: forward from history, then ages out after DEPTH+1 idle edges
    s4(1, 1, 7, 32'h11);
    tick();
    s4(0, 0, 0, 0); s3(1, 7);
    fwd("t2.hist0", 1, 32'h11, 1);
    s3(0, 0);
    tick();
    s3(1, 7);
    fwd("t2.hist1", 1, 32'h11, 2);
    s3(0, 0);
    tick(); tick();
    s3(1, 7);
    fwd("t2.aged", 0, 0, 0);
    s3(0, 0);

    // 3: shadowing by a younger ALU writer, and youngest-load priority
    s4(1, 1, 3, 32'hAA); tick();
    s4(1, 0, 3, 32'h55); tick();
    s4(0, 0, 0, 0); s3(1, 3);
    fwd("t3.shadow", 0, 0, 0);
    s3(0, 0);
    s4(1, 1, 3, 32'hAA); tick();
    s4(1, 1, 3, 32'hBB); tick();
    s4(0, 0, 0, 0); s3(1, 3);
    fwd("t3.young", 1, 32'hBB, 1);
    s4(1, 0, 3, 32'h77);
    fwd("t3.liveshadow", 0, 0, 0);
    s4(0, 0, 0, 0);
    tick();
    #1 check("t3.count", {16'd0, FWD_COUNT}, 32'd2);
    fwd("t3.aged1", 1, 32'hBB, 2);
    s3(0, 0);

    // 4: x0 and non-store never forward
    s4(1, 1, 0, 32'h123); s3(1, 0);
    fwd("t4.x0", 0, 0, 0);
    tick();
    s4(1, 1, 9, 32'h99); s3(0, 9);
    fwd("t4.nostore", 0, 0, 0);
    tick();
    s4(0, 0, 0, 0);
    #1 check("t4.count", {16'd0, FWD_COUNT}, 32'd2);
    s3(1, 9);
    fwd("t4.x9hist", 1, 32'h99, 1);
    s3(0, 0);

    // 5: stall holds history and counter; flush beats stall
    s4(1, 1, 4, 32'h44); tick();
    s4(0, 0, 0, 0); STALL = 1'b1; s3(1, 4);
    for (int i = 0; i < 3; i++) begin
      fwd("t5.stall", 1, 32'h44, 1);
      tick();
    end
    fwd("t5.stall", 1, 32'h44, 1);
    check("t5.count", {16'd0, FWD_COUNT}, 32'd2);
    FLUSH = 1'b1;
    fwd("t5.preflush", 1, 32'h44, 1);
    tick();
    FLUSH = 1'b0; STALL = 1'b0;
    fwd("t5.flushed", 0, 0, 0);
    check("t5.count2", {16'd0, FWD_COUNT}, 32'd2);
    s3(0, 0);

    // 6: asynchronous reset between edges
    s4(1, 1, 6, 32'h66); tick();
    s4(0, 0, 0, 0); s3(1, 6);
    fwd("t6.pre", 1, 32'h66, 1);
    RESET = 1'b0;
    fwd("t6.rst", 0, 0, 0);
    check("t6.count", {16'd0, FWD_COUNT}, 32'd0);
    RESET = 1'b1;
    fwd("t6.after", 0, 0, 0);
    tick();
    fwd("t6.fresh", 0, 0, 0);

    // Saturation: forward on every edge from a live load of x8
    s4(1, 1, 8, 32'h88); s3(1, 8);
    for (int i = 0; i < 15; i++) tick();
    check("sat.c4_15", {28'd0, FWD_COUNT_4}, 32'hF);
    for (int i = 0; i < 5; i++) tick();
    check("sat.c4_hold", {28'd0, FWD_COUNT_4}, 32'hF);
    check("sat.c16", {16'd0, FWD_COUNT}, 32'd20);
    s4(0, 0, 0, 0); s3(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stage4_load_forward_buffer.md
Name: stage4_load_forward_buffer

Overview:
- Parametrised successor to the single-compare stage-4 load→store forward mux.
- Tracks the live stage-4 writeback plus a DEPTH-entry history of retired writebacks.
- When a stage-3 store's rs2 matches the youngest in-flight writer of that register, and that writer is a load, it supplies the load data and a source index to the store-data mux.
- Younger non-load writers shadow older loads. Also supports stall, flush and a saturating forward-event counter.

Parameters:
- DATA_WIDTH, 32, width of load data and forwarded data.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 2, number of history entries behind stage 4 (≥1).
- CNT_WIDTH, 16, width of the forward-event counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  pipeline stall; history and counter hold.
- FLUSH  in  1  pipeline flush; clears history.
- S4_REG_WRITE  in  1  stage-4 instruction writes a register.
- S4_MEM_READ  in  1  stage-4 instruction is a load.
- S4_REG_ADDR  in  ADDR_WIDTH  stage-4 destination register.
- S4_LOAD_DATA  in  DATA_WIDTH  stage-4 load result.
- S3_MEM_WRITE  in  1  stage-3 instruction is a store.
- S3_REG_READ_ADDR2  in  ADDR_WIDTH  stage-3 rs2 (store data source).
- FWD_EN  out  1  select forwarded data for the store.
- FWD_DATA  out  DATA_WIDTH  forwarded load data.
- FWD_IDX  out  clog2(DEPTH+1)  source: 0 = live stage 4, k = history entry k-1.
- FWD_COUNT  out  CNT_WIDTH  saturating count of forward events.

Behaviour:
History storage:
- Entry fields: valid, is_load, addr, data. Entry 0 is youngest.

Reset (RESET=0, asynchronous):
- All valid, is_load, addr and data fields cleared to 0.
- FWD_COUNT = 0.
- With no match, outputs are FWD_EN=0, FWD_DATA=0, FWD_IDX=0.

Capture and shift (rising CLK, STALL=0, FLUSH=0):
- Entry k shifts to entry k+1; entry DEPTH-1 is discarded.
- Entry 0 loads: valid = S4_REG_WRITE && S4_REG_ADDR≠0; is_load = S4_MEM_READ; addr = S4_REG_ADDR; data = S4_LOAD_DATA.
- Data is captured regardless of is_load.

Flush and stall:
- FLUSH=1: all valid bits cleared at the edge. FLUSH dominates STALL.
- STALL=1 (FLUSH=0): all entries and FWD_COUNT hold.

Match (combinational, zero latency):
- Active only if S3_MEM_WRITE=1 and S3_REG_READ_ADDR2≠0.
- Candidate 0 is the live stage 4 (valid = S4_REG_WRITE && S4_REG_ADDR≠0). Candidates 1..DEPTH are history entries 0..DEPTH-1.
- Candidates are scanned youngest first (0 then 1..DEPTH); the first with valid and matching addr decides.
- Decider is_load=1 → FWD_EN=1, FWD_DATA = its data, FWD_IDX = its candidate index.
- Decider is_load=0 → shadowed: FWD_EN=0, FWD_DATA=0, FWD_IDX=0. The ALU forward path owns this case.
- No decider → FWD_EN=0, FWD_DATA=0, FWD_IDX=0.
- x0 never matches.
- With FLUSH=1 in the same cycle, the match still uses pre-flush state; the flush takes effect only at the edge.

Counter:
- At a rising edge with FWD_EN=1 and STALL=0, FWD_COUNT increments by 1.
- It saturates at all-ones and does not wrap.
- FLUSH does not clear FWD_COUNT.

Mid-operation reset:
- Deassertion behaves as a fresh start; no forward is possible until a capture occurs.

Test Plan:
1. Reset, then S4 load x5 data 0xDEADBEEF with S3 store rs2=x5 in the same cycle → FWD_EN=1, FWD_DATA=0xDEADBEEF, FWD_IDX=0. After the edge, FWD_COUNT=1.
2. Load x7 data 0x11 captured; next cycle S4 idle, S3 store rs2=x7 → FWD_EN=1, FWD_DATA=0x11, FWD_IDX=1. After DEPTH+1 idle edges the same query → FWD_EN=0.
3. Shadowing: load x3 data 0xAA captured; next cycle S4 ALU write x3 (S4_MEM_READ=0); the following cycle S3 store rs2=x3 → FWD_EN=0 (history entry 0 non-load decides). Also, load x3 data 0xBB in entry 0 with older load x3 data 0xAA in entry 1 → FWD_DATA=0xBB, FWD_IDX=1.
4. x0 and non-store cases: S4 load x0, S3 store rs2=x0 → FWD_EN=0. S4 load x9, S3 rs2=x9 with S3_MEM_WRITE=0 → FWD_EN=0. FWD_COUNT unchanged in both.
5. Stall and flush:
   - Load x4 data 0x44 captured, then STALL=1 for 3 edges; store rs2=x4 → FWD_IDX=1 throughout, FWD_COUNT frozen.
   - Then FLUSH=1 with STALL=1 for one edge; store rs2=x4 → FWD_EN=0.
6. Async reset mid-stream: history holding load x6, RESET pulled low between edges → entries clear immediately; store rs2=x6 → FWD_EN=0 and FWD_COUNT=0 before the next CLK edge. Separately, FWD_COUNT preset to all-ones by repeated forwards (CNT_WIDTH=4 build) → holds at 0xF.
